// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with double-buffered value/dp capture.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       idx, idx_nx;
    logic [15:0]      shadow, shadow_nx, pend;
    logic [3:0]       shadow_dp, shadow_dp_nx, pend_dp;
    logic             pend_valid;
    logic             tick, boundary;
    logic [3:0]       blank, an_nx;

    always_comb begin
        tick         = enable && (cnt == LAST);
        boundary     = tick && (idx == 2'd3);
        cnt_nx       = cnt;
        if (enable)
            cnt_nx = tick ? '0 : cnt + CNT_W'(1);
        idx_nx       = tick ? idx + 2'd1 : idx;
        shadow_nx    = shadow;
        shadow_dp_nx = shadow_dp;
        // A load landing on the boundary bypasses pending so it shows this frame.
        if (boundary && load) begin
            shadow_nx    = value;
            shadow_dp_nx = dp_in;
        end else if (boundary && pend_valid) begin
            shadow_nx    = pend;
            shadow_dp_nx = pend_dp;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank    = '0;
        blank[3] = (shadow_nx[15:12] == 4'h0) && !shadow_dp_nx[3];
        blank[2] = blank[3] && (shadow_nx[11:8] == 4'h0) && !shadow_dp_nx[2];
        blank[1] = blank[2] && (shadow_nx[7:4] == 4'h0) && !shadow_dp_nx[1];
    end
`else
    assign blank = '0;
`endif

    assign an_nx = ~(4'b0001 << idx_nx) | blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            shadow_dp   <= '0;
            pend        <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            hex         <= 4'h0;
            an          <= 4'hf;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            shadow    <= shadow_nx;
            shadow_dp <= shadow_dp_nx;
            if (load && !boundary) begin
                pend       <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
            // Outputs track the next index so they switch on the same edge.
            hex         <= shadow_nx[4*idx_nx +: 4];
            an          <= enable ? an_nx : 4'hf;
            dp          <= enable ? ~shadow_dp_nx[idx_nx] : 1'b1;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver against a slot-level reference model.
module tb_seg_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  hex, an;
    logic        dp, frame_start;

    int checks = 0;
    int failures = 0;
    bit done = 0;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t sb[$];

    seg_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value(value), .dp_in(dp_in), .hex(hex), .an(an), .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference state: position within the slot, digit shown, displayed and queued data.
    int          m_pos, m_digit;
    logic [15:0] m_show, m_queued;
    logic [3:0]  m_show_dp, m_queued_dp;
    bit          m_has_queued;

    function automatic exp_t model_step(bit r, bit en, bit ld, logic [15:0] v, logic [3:0] d);
        exp_t e;
        bit slot_end, frame_end;
        e = '0;
        if (r) begin
            m_pos = 0; m_digit = 0; m_show = 0; m_show_dp = 0;
            m_queued = 0; m_queued_dp = 0; m_has_queued = 0;
            e.hex = 4'h0; e.an = 4'hf; e.dp = 1'b1; e.fs = 1'b0;
            return e;
        end
        slot_end  = en && (m_pos == DIV - 1);
        frame_end = slot_end && (m_digit == 3);
        if (frame_end) begin
            if (ld) begin m_show = v; m_show_dp = d; end
            else if (m_has_queued) begin m_show = m_queued; m_show_dp = m_queued_dp; end
            m_has_queued = 0;
        end else if (ld) begin
            m_queued = v; m_queued_dp = d; m_has_queued = 1;
        end
        if (en) begin
            m_pos = (m_pos + 1) % DIV;
            if (slot_end) m_digit = (m_digit + 1) % 4;
        end
        e.hex = 4'((m_show >> (4 * m_digit)) & 16'hf);
        e.fs  = frame_end;
        if (en) begin
            e.an = 4'hf & ~(4'd1 << m_digit);
            e.dp = !m_show_dp[m_digit];
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 1; i < 4; i++)
                if ((m_show >> (4 * i)) == 0 && (m_show_dp >> i) == 0)
                    e.an[i] = 1'b1;
`endif
        end else begin
            e.an = 4'hf;
            e.dp = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(bit r, bit en, bit ld, logic [15:0] v, logic [3:0] d);
        @(negedge clk);
        reset = r; enable = en; load = ld; value = v; dp_in = d;
        sb.push_back(model_step(r, en, ld, v, d));
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (hex !== e.hex || an !== e.an || dp !== e.dp || frame_start !== e.fs) begin
                    failures++;
                    $display("FAIL outputs t=%0t got hex=%h an=%b dp=%b fs=%b want hex=%h an=%b dp=%b fs=%b",
                             $time, hex, an, dp, frame_start, e.hex, e.an, e.dp, e.fs);
                end
            end
        end
    end

    initial begin
        reset = 1; enable = 0; load = 0; value = 0; dp_in = 0;
        repeat (3) drive(1, 1, 0, 16'h0, 4'h0);
        // Directed opener: mid-frame load, then back-to-back loads within one frame.
        repeat (6) drive(0, 1, 0, 16'h0, 4'h0);
        drive(0, 1, 1, 16'h1234, 4'b0100);
        repeat (40) drive(0, 1, 0, 16'h0, 4'h0);
        drive(0, 1, 1, 16'hAAAA, 4'h0);
        repeat (3) drive(0, 1, 0, 16'h0, 4'h0);
        drive(0, 1, 1, 16'hBEEF, 4'h0);
        repeat (30) drive(0, 1, 0, 16'h0, 4'h0);
        drive(0, 0, 1, 16'h0050, 4'h0);
        repeat (10) drive(0, 0, 0, 16'h0, 4'h0);
        repeat (40) drive(0, 1, 0, 16'h0, 4'h0);
        for (int n = 0; n < 4000; n++) begin
            bit r, en, ld;
            logic [15:0] v;
            logic [3:0] d;
            r  = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: v = 16'h0;
                1: v = 16'($urandom_range(0, 255));
                default: v = 16'($urandom);
            endcase
            d = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            drive(r, en, ld, v, d);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
